// File: rtl/lcd_frame_source.sv
// rtl/lcd_frame_source.sv - raster counters and built-in test patterns feeding the 7:1 LVDS serializer
module lcd_frame_source #(
   parameter int H_ACTIVE     = 1024,
   parameter int H_SYNC_START = 1152,
   parameter int H_TOTAL      = 1173,
   parameter int V_ACTIVE     = 310,
   parameter int V_SYNC_START = 311,
   parameter int V_SYNC_END   = 313,
   parameter int V_TOTAL      = 330,
   parameter int SCROLL_STEP  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_stb,
   input  logic [2:0] pattern_sel,
   output logic       de,
   output logic       hsync,
   output logic       vsync,
   output logic [5:0] red,
   output logic [5:0] green,
   output logic [5:0] blue,
   output logic       frame_start
);

   // Raster limits sized to the counters they are compared against
   localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
   localparam logic [10:0] H_LAST    = 11'(H_ACTIVE - 1);
   localparam logic [10:0] H_SS      = 11'(H_SYNC_START);
   localparam logic [10:0] H_END     = 11'(H_TOTAL - 1);
   localparam logic [8:0]  V_ACT     = 9'(V_ACTIVE);
   localparam logic [8:0]  V_LAST    = 9'(V_ACTIVE - 1);
   localparam logic [8:0]  V_SS      = 9'(V_SYNC_START);
   localparam logic [8:0]  V_SE      = 9'(V_SYNC_END);
   localparam logic [8:0]  V_END     = 9'(V_TOTAL - 1);
   localparam logic [10:0] OFF_STEP  = 11'(SCROLL_STEP);
   localparam logic [10:0] OFF_LIMIT = 11'(H_ACTIVE - 32);
   localparam logic [10:0] BAR_WIDTH = 11'd32;

   logic [10:0] h_cnt;
   logic [8:0]  v_cnt;
   logic [2:0]  pattern_q;
   logic [9:0]  offset_q;

   logic        at_line_end;
   logic        at_frame_end;
   logic [10:0] offset_sum;
   logic [9:0]  offset_next;
   logic [10:0] bar_start;
   logic [10:0] bar_end;
   logic [2:0]  bar_rgb;

   logic        f_de;
   logic        f_hsync;
   logic        f_vsync;
   logic [5:0]  f_red;
   logic [5:0]  f_green;
   logic [5:0]  f_blue;

   // Raster position decode and the next scroll offset taken at frame wrap
   always_comb begin
      at_line_end  = (h_cnt == H_END);
      at_frame_end = at_line_end && (v_cnt == V_END);
      offset_sum   = {1'b0, offset_q} + OFF_STEP;
      offset_next  = (offset_sum > OFF_LIMIT) ? 10'd0 : offset_sum[9:0];
      bar_start    = {1'b0, offset_q};
      bar_end      = {1'b0, offset_q} + BAR_WIDTH;
   end

   // Colour bar lookup: {r,g,b} on/off for the eight bars of 128 columns
   always_comb begin
      bar_rgb = 3'b000;
      case (h_cnt[9:7])
         3'd0:    bar_rgb = 3'b111;
         3'd1:    bar_rgb = 3'b110;
         3'd2:    bar_rgb = 3'b011;
         3'd3:    bar_rgb = 3'b010;
         3'd4:    bar_rgb = 3'b101;
         3'd5:    bar_rgb = 3'b100;
         3'd6:    bar_rgb = 3'b001;
         default: bar_rgb = 3'b000;
      endcase
   end

   // Pixel function of the current raster position; no pipeline stage
   always_comb begin
      f_de    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      f_hsync = (h_cnt >= H_SS);
      f_vsync = (v_cnt >= V_SS) && (v_cnt < V_SE);
      f_red   = 6'd0;
      f_green = 6'd0;
      f_blue  = 6'd0;
      if (f_de) begin
         case (pattern_q)
            3'd0: begin
               f_red   = 6'd0;
            end
            3'd1: begin
               if ((v_cnt == 9'd0) || (v_cnt == V_LAST)) f_red  = 6'd63;
               if ((h_cnt == 11'd0) || (h_cnt == H_LAST)) f_blue = 6'd63;
            end
            3'd2: begin
               f_red   = {6{bar_rgb[2]}};
               f_green = {6{bar_rgb[1]}};
               f_blue  = {6{bar_rgb[0]}};
            end
            3'd3: begin
               f_red   = h_cnt[9:4];
               f_green = h_cnt[9:4];
               f_blue  = h_cnt[9:4];
            end
            3'd4: begin
               if (h_cnt[5] ^ v_cnt[5]) begin
                  f_red   = 6'd63;
                  f_green = 6'd63;
                  f_blue  = 6'd63;
               end
            end
            3'd5: begin
               if ((h_cnt >= bar_start) && (h_cnt < bar_end)) begin
                  f_red   = 6'd63;
                  f_green = 6'd63;
                  f_blue  = 6'd63;
               end
            end
            default: begin
               f_red   = 6'd63;
               f_green = 6'd63;
               f_blue  = 6'd63;
            end
         endcase
      end
   end

   // Raster counters advance once per strobe, wrapping line then frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= 11'd0;
         v_cnt <= 9'd0;
      end else if (pix_stb) begin
         if (at_line_end) begin
            h_cnt <= 11'd0;
            if (v_cnt == V_END) v_cnt <= 9'd0;
            else                v_cnt <= v_cnt + 9'd1;
         end else begin
            h_cnt <= h_cnt + 11'd1;
         end
      end
   end

   // Pattern and scroll offset only change at frame wrap so a frame is never mixed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern_q <= 3'd0;
         offset_q  <= 10'd0;
      end else if (pix_stb && at_frame_end) begin
         pattern_q <= pattern_sel;
         offset_q  <= offset_next;
      end
   end

   // Registered pixel word, held between strobes; frame_start is a single-cycle pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         de          <= 1'b0;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         red         <= 6'd0;
         green       <= 6'd0;
         blue        <= 6'd0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (pix_stb) begin
            de          <= f_de;
            hsync       <= f_hsync;
            vsync       <= f_vsync;
            red         <= f_red;
            green       <= f_green;
            blue        <= f_blue;
            frame_start <= (h_cnt == 11'd0) && (v_cnt == 9'd0);
         end
      end
   end

endmodule
